cpu_sequencer: RTL

Multi-cycle control sequencer for the 8-bit accumulator computer. It owns the program counter and instruction register, and fetches from the 32-entry combinational instruction memory (5-bit address, 8-bit data). It decodes each instruction and drives the ALU, accumulator and data-memory strobes of the datapath. It supports run, single-step and halt, so one program image can be exercised by the bench or a debug front end.

---
 rtl/cpu_pkg.sv | 50 +++++
 rtl/cpu_decoder.sv | 56 +++++
 rtl/cpu_sequencer.sv | 135 +++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared encodings for the accumulator computer control sequencer:
// opcodes, SYS sub-codes, ALU operation selects and sequencer states.
package cpu_pkg;

   // Major opcodes, ir[7:5]
   localparam logic [2:0] OP_ADD   = 3'd0;
   localparam logic [2:0] OP_SUB   = 3'd1;
   localparam logic [2:0] OP_AND   = 3'd2;
   localparam logic [2:0] OP_OR    = 3'd3;
   localparam logic [2:0] OP_XOR   = 3'd4;
   localparam logic [2:0] OP_LOAD  = 3'd5;
   localparam logic [2:0] OP_STORE = 3'd6;
   localparam logic [2:0] OP_SYS   = 3'd7;

   // SYS sub-operations, carried in the operand field ir[4:0]
   localparam logic [4:0] SYS_NOP  = 5'd0;
   localparam logic [4:0] SYS_HALT = 5'd1;
   localparam logic [4:0] SYS_CLR  = 5'd2;
   localparam logic [4:0] SYS_NOT  = 5'd3;

   // ALU operation selects driven onto alu_op
   localparam logic [2:0] ALU_ADD    = 3'd0;
   localparam logic [2:0] ALU_SUB    = 3'd1;
   localparam logic [2:0] ALU_AND    = 3'd2;
   localparam logic [2:0] ALU_OR     = 3'd3;
   localparam logic [2:0] ALU_XOR    = 3'd4;
   localparam logic [2:0] ALU_PASS_B = 3'd5;
   localparam logic [2:0] ALU_ZERO   = 3'd6;
   localparam logic [2:0] ALU_NOT_A  = 3'd7;

   // Sequencer states
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_EXEC   = 3'd2,
      ST_PAUSE  = 3'd3,
      ST_HALTED = 3'd4
   } state_e;

   // Opcode field of an instruction word
   function automatic logic [2:0] ir_opcode(input logic [7:0] ir);
      return ir[7:5];
   endfunction

   // Operand field of an instruction word
   function automatic logic [4:0] ir_operand(input logic [7:0] ir);
      return ir[4:0];
   endfunction

endpackage

// File: rtl/cpu_decoder.sv
// Combinational instruction decoder: maps the instruction register onto
// datapath controls. Strobes are ungated here; the sequencer qualifies
// them with its EXEC state.
module cpu_decoder
   import cpu_pkg::*;
(
   input  logic [7:0] ir_i,
   output logic [2:0] alu_op_o,
   output logic       acc_we_o,
   output logic       acc_src_o,
   output logic       dmem_we_o,
   output logic [4:0] dmem_addr_o,
   output logic       is_halt_o
);

   logic [2:0] op_s;
   logic [4:0] operand_s;

   assign op_s      = ir_opcode(ir_i);
   assign operand_s = ir_operand(ir_i);

   // Decode opcode and SYS sub-code into ALU select, strobes and address
   always_comb begin
      alu_op_o    = ALU_ADD;
      acc_we_o    = 1'b0;
      acc_src_o   = 1'b0;
      dmem_we_o   = 1'b0;
      dmem_addr_o = operand_s;
      is_halt_o   = 1'b0;
      case (op_s)
         OP_ADD:   begin alu_op_o = ALU_ADD; acc_we_o = 1'b1; end
         OP_SUB:   begin alu_op_o = ALU_SUB; acc_we_o = 1'b1; end
         OP_AND:   begin alu_op_o = ALU_AND; acc_we_o = 1'b1; end
         OP_OR:    begin alu_op_o = ALU_OR;  acc_we_o = 1'b1; end
         OP_XOR:   begin alu_op_o = ALU_XOR; acc_we_o = 1'b1; end
         OP_LOAD:  begin
            alu_op_o  = ALU_PASS_B;
            acc_we_o  = 1'b1;
            acc_src_o = 1'b1;
         end
         OP_STORE: dmem_we_o = 1'b1;
         OP_SYS:   begin
            // SYS carries no memory operand, so the address is parked at 0
            dmem_addr_o = 5'd0;
            case (operand_s)
               SYS_HALT: is_halt_o = 1'b1;
               SYS_CLR:  begin alu_op_o = ALU_ZERO;  acc_we_o = 1'b1; end
               SYS_NOT:  begin alu_op_o = ALU_NOT_A; acc_we_o = 1'b1; end
               default:  is_halt_o = 1'b0;
            endcase
         end
         default:  acc_we_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle control sequencer: owns PC and IR, fetches from a
// combinational instruction memory and drives datapath strobes for one
// EXEC cycle per instruction. Supports run, single-step and halt.
module cpu_sequencer
   import cpu_pkg::*;
#(
   parameter logic [4:0] START_PC = 5'd0,
   parameter int         CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             step_mode,
   input  logic             step,
   output logic [4:0]       imem_addr,
   input  logic [7:0]       imem_data,
   output logic [4:0]       dmem_addr,
   output logic             dmem_we,
   output logic [2:0]       alu_op,
   output logic             acc_we,
   output logic             acc_src,
   output logic [4:0]       pc,
   output logic             busy,
   output logic             halted,
   output logic [CNT_W-1:0] retired
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_e           state_q, state_d;
   logic [4:0]       pc_q, pc_d;
   logic [7:0]       ir_q, ir_d;
   logic [CNT_W-1:0] retired_q, retired_d;

   logic       dec_acc_we_s, dec_acc_src_s, dec_dmem_we_s, dec_is_halt_s;
   logic [2:0] dec_alu_op_s;
   logic [4:0] dec_dmem_addr_s;
   logic       exec_s;

   cpu_decoder u_decoder (
      .ir_i        (ir_q),
      .alu_op_o    (dec_alu_op_s),
      .acc_we_o    (dec_acc_we_s),
      .acc_src_o   (dec_acc_src_s),
      .dmem_we_o   (dec_dmem_we_s),
      .dmem_addr_o (dec_dmem_addr_s),
      .is_halt_o   (dec_is_halt_s)
   );

   // State, PC, IR and retired-count registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         pc_q      <= START_PC;
         ir_q      <= 8'd0;
         retired_q <= {CNT_W{1'b0}};
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         ir_q      <= ir_d;
         retired_q <= retired_d;
      end
   end

   // Next-state logic: fetch/exec loop, step pause and halt handling
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      ir_d      = ir_q;
      retired_d = retired_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               pc_d    = START_PC;
               state_d = ST_FETCH;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_FETCH: begin
            ir_d    = imem_data;
            state_d = ST_EXEC;
         end
         ST_EXEC: begin
            // HALT retires too; the counter sticks at all ones
            if (retired_q != CNT_MAX) begin
               retired_d = retired_q + CNT_ONE;
            end else begin
               retired_d = retired_q;
            end
            if (dec_is_halt_s) begin
               state_d = ST_HALTED;
            end else begin
               pc_d = pc_q + 5'd1;
               if (step_mode) begin
                  state_d = ST_PAUSE;
               end else begin
                  state_d = ST_FETCH;
               end
            end
         end
         ST_PAUSE: begin
            // Leaving step mode releases the pause just like a step pulse
            if (step || !step_mode) begin
               state_d = ST_FETCH;
            end else begin
               state_d = ST_PAUSE;
            end
         end
         ST_HALTED: begin
            if (start) begin
               pc_d    = START_PC;
               state_d = ST_FETCH;
            end else begin
               state_d = ST_HALTED;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign exec_s    = (state_q == ST_EXEC);
   assign imem_addr = pc_q;
   assign pc        = pc_q;
   assign retired   = retired_q;
   assign busy      = (state_q == ST_FETCH) || exec_s;
   assign halted    = (state_q == ST_HALTED);
   assign alu_op    = dec_alu_op_s;
   assign dmem_addr = dec_dmem_addr_s;
   assign acc_we    = dec_acc_we_s  & exec_s;
   assign acc_src   = dec_acc_src_s & exec_s;
   assign dmem_we   = dec_dmem_we_s & exec_s;

endmodule
